mem_issue_sched: RTL
====================

Name: mem_issue_sched

Overview:
- In-order scheduler between the 2-wide head window of the memory issue queue and two memory issue ports.
  - Port 0 carries loads and stores; port 1 carries loads only.
- Decides how many head entries to consume each cycle (`take`) and holds issued ops in per-port output registers.
- Limits in-flight memory ops with a credit counter.
- Sequences fences (drain, then retire the fence) and pipeline flushes.

Parameters:
- CREDITS, 4: maximum memory ops taken from the queue and not yet responded (includes ops held in output registers).
- TAG_W, 6: width of the ROB tag carried with each op.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cand_valid  in  2  head entries 0/1 valid and operands ready.
- cand_is_store  in  2  per-candidate store flag.
- cand_is_fence  in  2  per-candidate fence flag.
- cand_tag  in  2*TAG_W  per-candidate ROB tag; candidate i occupies bits [i*TAG_W +: TAG_W].
- take  out  2  entries consumed this cycle (combinational); thermometer code, take[1] implies take[0].
- flush  in  1  kill all not-yet-accepted ops.
- iss_valid  out  2  port output register valid.
- iss_ready  in  2  port accepts this cycle.
- iss_tag  out  2*TAG_W  port tags.
- iss_is_store  out  1  port-0 store flag.
- resp_valid  in  2  completion responses this cycle; each set bit returns one credit.
- outstanding  out  $clog2(CREDITS+1)  current credit usage.
- busy  out  1  state != RUN or outstanding != 0.

Behaviour:
- Reset (asynchronous): iss_valid=0, iss_tag=0, iss_is_store=0, outstanding=0, state=RUN, take=0, busy=0.
- Free signals: free0 = ~iss_valid[0] | iss_ready[0]; free1 = ~iss_valid[1] | iss_ready[1].
- Port handshake: an op transfers when iss_valid & iss_ready on that port. The register is reloaded the same cycle if a new take targets it; otherwise iss_valid clears.
- Credit check uses registered `outstanding` only; there is no same-cycle bypass of returned credits.
- State RUN:
  - take[0] = cand_valid[0] & ~cand_is_fence[0] & free0 & (outstanding < CREDITS) & ~flush.
  - take[1] = take[0] & cand_valid[1] & ~cand_is_store[0] & ~cand_is_store[1] & ~cand_is_fence[1] & free1 & (outstanding+2 <= CREDITS).
  - Taken entry 0 loads port 0; taken entry 1 loads port 1. Latency is 1 cycle from take to iss_valid.
  - cand_valid[0] & cand_is_fence[0] & ~flush -> FENCE_WAIT, take=0.
- State FENCE_WAIT:
  - take=0 while outstanding != 0. outstanding==0 implies both output registers are empty.
  - When outstanding==0 & ~flush: take=2'b01 (fence consumed, never issued), return to RUN.
  - Next cycle normal issue resumes.
- flush (any state, highest priority):
  - take=0; iss_valid cleared next cycle (accepts on that same cycle still count).
  - outstanding -= number of valid output registers not accepted this cycle.
  - state -> FLUSH_WAIT if the resulting outstanding != 0, else RUN.
- State FLUSH_WAIT: take=0 until outstanding==0, then -> RUN.
- Counter update: outstanding_next = outstanding + popcount(take & ~fence consume) − popcount(resp_valid) − flushed_regs.
  - Computed at $clog2(CREDITS+1)+1 bits.
  - A response at outstanding==0 is a protocol error: the counter saturates at 0, and a simulation-only assertion fires.
- Simultaneous take and resp in one cycle: both apply. Credit freed by a resp is usable the next cycle.
- Port 1 never carries a store; a store at candidate 0 blocks dual issue.

Test Plan:
- Two loads at head, both ports ready, outstanding=0 -> take=2'b11; next cycle iss_valid=2'b11 with the matching tags; outstanding=2.
- Store at cand 0 plus load at cand 1 -> take=2'b01; port 0 issues with iss_is_store=1; the load takes on the following cycle.
- CREDITS=4, outstanding=3, two loads -> take=2'b01 only; with outstanding=4 -> take=0 until a resp_valid bit is seen, then take=2'b01 the next cycle.
- Fence at cand 0 with outstanding=2:
  - FENCE_WAIT, take=0.
  - resp 2'b11 -> outstanding=0.
  - Following cycle take=2'b01 and state RUN.
- iss_ready=0 with both ports valid and outstanding=3, flush=1 -> iss_valid=0 next cycle; outstanding=1; FLUSH_WAIT; take stays 0 until one resp, then RUN.
- Assert reset mid-issue with iss_valid=2'b11 -> outputs clear immediately without a clock edge; after release, busy=0 and take follows the RUN rules.

Source files
------------

// File: rtl/mem_issue_sched.sv
// mem_issue_sched: in-order 2-wide memory issue scheduler with credit limit,
// fence drain and flush sequencing.
module mem_issue_sched #(
  parameter int CREDITS = 4,
  parameter int TAG_W = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    cand_valid,
  input  logic [1:0]                    cand_is_store,
  input  logic [1:0]                    cand_is_fence,
  input  logic [2*TAG_W-1:0]            cand_tag,
  output logic [1:0]                    take,
  input  logic                          flush,
  output logic [1:0]                    iss_valid,
  input  logic [1:0]                    iss_ready,
  output logic [2*TAG_W-1:0]            iss_tag,
  output logic                          iss_is_store,
  input  logic [1:0]                    resp_valid,
  output logic [$clog2(CREDITS+1)-1:0]  outstanding,
  output logic                          busy
);
  localparam int OW = $clog2(CREDITS+1);
  localparam logic [OW:0] CRED = (OW+1)'(CREDITS);
  localparam logic [1:0] RUN = 2'd0, FENCE_WAIT = 2'd1, FLUSH_WAIT = 2'd2;
  logic [1:0] state, state_next, ld, held;
  logic run_t0, run_t1;
  logic [OW:0] out_w, add, sub, sum;
  logic [OW-1:0] out_next;
  assign out_w = {1'b0, outstanding};
  assign held = iss_valid & ~iss_ready;
  assign run_t0 = cand_valid[0] & ~cand_is_fence[0] & (~iss_valid[0] | iss_ready[0])
                & (out_w < CRED) & ~flush;
  assign run_t1 = run_t0 & cand_valid[1] & ~cand_is_store[0] & ~cand_is_store[1]
                & ~cand_is_fence[1] & (~iss_valid[1] | iss_ready[1])
                & (out_w + (OW+1)'(2) <= CRED);
  always_comb begin
    take = reset ? 2'b00
         : state == RUN ? {run_t1, run_t0}
         : (state == FENCE_WAIT && outstanding == '0 && !flush) ? 2'b01 : 2'b00;
  end
  // A fence is consumed outside RUN and never occupies a port or a credit.
  assign ld = take & {2{state == RUN}};
  assign add = (OW+1)'(ld[0]) + (OW+1)'(ld[1]);
  assign sub = (OW+1)'(resp_valid[0]) + (OW+1)'(resp_valid[1])
             + (flush ? (OW+1)'(held[0]) + (OW+1)'(held[1]) : '0);
  assign sum = out_w + add;
  assign out_next = sum >= sub ? OW'(sum - sub) : '0;
  always_comb begin
    state_next = flush ? (out_next != '0 ? FLUSH_WAIT : RUN)
               : state == RUN ? ((cand_valid[0] & cand_is_fence[0]) ? FENCE_WAIT : RUN)
               : state == FENCE_WAIT ? (take[0] ? RUN : FENCE_WAIT)
               : (outstanding == '0 ? RUN : FLUSH_WAIT);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      outstanding <= '0;
      iss_valid <= 2'b00;
      iss_tag <= '0;
      iss_is_store <= 1'b0;
    end else begin
      state <= state_next;
      outstanding <= out_next;
      iss_valid <= flush ? 2'b00 : (ld | held);
      if (ld[0]) begin
        iss_tag[0 +: TAG_W] <= cand_tag[0 +: TAG_W];
        iss_is_store <= cand_is_store[0];
      end
      if (ld[1]) iss_tag[TAG_W +: TAG_W] <= cand_tag[TAG_W +: TAG_W];
    end
  end
  assign busy = (state != RUN) | (outstanding != '0);
  a_resp_underflow: assert property (@(posedge clk) disable iff (reset)
    !((resp_valid != 2'b00) && (outstanding == '0)));
endmodule
